// File: rtl/str_pkt_arb.sv
// Packet-level round-robin arbiter: N_SRC AXI-Stream sources share one output, grant locked
// until tlast. Optional per-source packet counters under `STR_PKT_ARB_CNT_EN.
module str_pkt_arb #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 80,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned KW = DATA_WIDTH / WORD_WIDTH,
    localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_SRC-1:0]            i_src_en,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC*KW-1:0]         s_axis_tkeep,
    input  logic [N_SRC-1:0]            s_axis_tlast,
    input  logic [N_SRC-1:0]            s_axis_tvld,
    output logic [N_SRC-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KW-1:0]               m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvld,
    input  logic                        m_axis_trdy,
    output logic [SW-1:0]               m_axis_tid,
    output logic                        o_busy
`ifdef STR_PKT_ARB_CNT_EN
    ,
    output logic [N_SRC*CNT_WIDTH-1:0]  o_pkt_cnt
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Elaboration-time parameter sanity
    if (N_SRC < 2 || CNT_WIDTH < 1 || WORD_WIDTH < 1 || (DATA_WIDTH % WORD_WIDTH) != 0) begin : g_bad_param
        $error("str_pkt_arb: illegal parameter combination");
    end

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [SW-1:0]         r_rr_ptr;
    logic [SW-1:0]         w_rr_ptr_nxt;
    logic [SW-1:0]         r_gnt;
    logic [SW-1:0]         w_gnt_nxt;
    logic [SW-1:0]         w_arb_gnt;
    logic                  w_arb_hit;
    logic [N_SRC-1:0]      w_req;
    logic [N_SRC-1:0]      w_trdy;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_accept_last;

    logic                  r_tvld;
    logic                  w_tvld_nxt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0] w_tdata_nxt;
    logic [KW-1:0]         r_tkeep;
    logic [KW-1:0]         w_tkeep_nxt;
    logic                  r_tlast;
    logic                  w_tlast_nxt;
    logic [SW-1:0]         r_tid;
    logic [SW-1:0]         w_tid_nxt;

    logic [DATA_WIDTH-1:0] w_src_data [N_SRC];
    logic [KW-1:0]         w_src_keep [N_SRC];

    // Split flat source buses into per-source lanes
    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign w_src_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_src_keep[g] = s_axis_tkeep[g*KW +: KW];
    end

    function automatic logic [SW-1:0] f_wrap(input logic [SW-1:0] base, input int unsigned off);
        int unsigned k;
        k = 32'(base) + off;
        if (k >= N_SRC) k = k - N_SRC;
        return SW'(k);
    endfunction

    assign w_req      = s_axis_tvld & i_src_en;
    assign w_out_free = !r_tvld || m_axis_trdy;

    // Round-robin pick: first requester at or after rr_ptr
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_gnt = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!w_arb_hit && w_req[f_wrap(r_rr_ptr, i)]) begin
                w_arb_hit = 1'b1;
                w_arb_gnt = f_wrap(r_rr_ptr, i);
            end
        end
    end

    // Next-state, handshake and output-register next values
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_nxt     = r_gnt;
        w_trdy        = '0;
        w_accept      = 1'b0;
        w_accept_last = 1'b0;
        w_tvld_nxt    = r_tvld;
        w_tdata_nxt   = r_tdata;
        w_tkeep_nxt   = r_tkeep;
        w_tlast_nxt   = r_tlast;
        w_tid_nxt     = r_tid;

        if (r_tvld && m_axis_trdy) begin
            w_tvld_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    w_gnt_nxt   = w_arb_gnt;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                w_trdy[r_gnt] = w_out_free;
                w_accept      = s_axis_tvld[r_gnt] && w_out_free;
                w_accept_last = w_accept && s_axis_tlast[r_gnt];
                if (w_accept) begin
                    w_tvld_nxt  = 1'b1;
                    w_tdata_nxt = w_src_data[r_gnt];
                    w_tkeep_nxt = w_src_keep[r_gnt];
                    w_tlast_nxt = s_axis_tlast[r_gnt];
                    w_tid_nxt   = r_gnt;
                end
                // Packet boundary releases the lock and moves priority past the winner
                if (w_accept_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = (r_gnt == SW'(N_SRC - 1)) ? '0 : r_gnt + SW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_tvld   <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_tvld   <= w_tvld_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tkeep  <= w_tkeep_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tid    <= w_tid_nxt;
        end
    end

    assign s_axis_trdy  = w_trdy;
    assign m_axis_tvld  = r_tvld;
    assign m_axis_tdata = r_tdata;
    assign m_axis_tkeep = r_tkeep;
    assign m_axis_tlast = r_tlast;
    assign m_axis_tid   = r_tid;
    assign o_busy       = (r_state == ST_XFER);

`ifdef STR_PKT_ARB_CNT_EN
    // Per-source packet counters, bumped on the s-side tlast beat; wrap naturally
    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_pkt_cnt;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_pkt_cnt <= '0;
            end else if (w_accept_last && (r_gnt == SW'(g))) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            end
        end
        assign o_pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_pkt_cnt;
    end
`endif

endmodule

// File: tb/tb_str_pkt_arb.sv
// Directed testbench for str_pkt_arb (N_SRC=4, 80-bit data); counter checks under STR_PKT_ARB_CNT_EN.
module tb_str_pkt_arb;
    localparam int unsigned N_SRC = 4;
    localparam int unsigned DW    = 80;
    localparam int unsigned WW    = 8;
    localparam int unsigned KW    = DW / WW;
    localparam int unsigned SW    = 2;
`ifdef STR_PKT_ARB_CNT_EN
    localparam int unsigned CW    = 2;
`endif

    logic                clk;
    logic                rst_n;
    logic [N_SRC-1:0]    src_en;
    logic [N_SRC*DW-1:0] s_tdata;
    logic [N_SRC*KW-1:0] s_tkeep;
    logic [N_SRC-1:0]    s_tlast;
    logic [N_SRC-1:0]    s_tvld;
    logic [N_SRC-1:0]    s_trdy;
    logic [DW-1:0]       m_tdata;
    logic [KW-1:0]       m_tkeep;
    logic                m_tlast;
    logic                m_tvld;
    logic                m_trdy;
    logic [SW-1:0]       m_tid;
    logic                busy;
`ifdef STR_PKT_ARB_CNT_EN
    logic [N_SRC*CW-1:0] pkt_cnt;
`endif

    logic [DW-1:0] tb_tdata [N_SRC];
    logic [KW-1:0] tb_tkeep [N_SRC];
    logic          tb_tlast [N_SRC];
    logic          tb_tvld  [N_SRC];
    logic          tb_trdy  [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_map
        assign s_tdata[g*DW +: DW] = tb_tdata[g];
        assign s_tkeep[g*KW +: KW] = tb_tkeep[g];
        assign s_tlast[g]          = tb_tlast[g];
        assign s_tvld[g]           = tb_tvld[g];
        assign tb_trdy[g]          = s_trdy[g];
    end

    str_pkt_arb #(
        .N_SRC      (N_SRC),
        .DATA_WIDTH (DW),
        .WORD_WIDTH (WW)
`ifdef STR_PKT_ARB_CNT_EN
        ,.CNT_WIDTH (CW)
`endif
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_src_en     (src_en),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tvld  (s_tvld),
        .s_axis_trdy  (s_trdy),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvld  (m_tvld),
        .m_axis_trdy  (m_trdy),
        .m_axis_tid   (m_tid),
        .o_busy       (busy)
`ifdef STR_PKT_ARB_CNT_EN
        ,.o_pkt_cnt   (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source models: packets remaining, length, current beat, packet index, optional stall
    int src_pkts [N_SRC];
    int src_len  [N_SRC];
    int src_beat [N_SRC];
    int src_pkt  [N_SRC];
    int src_stall_beat [N_SRC];
    int src_stall_left [N_SRC];
    logic trdy_seen [N_SRC];
    logic m_rand;

    logic [SW-1:0] q_tid  [$];
    logic [DW-1:0] q_data [$];
    logic [KW-1:0] q_keep [$];
    logic          q_last [$];

    int            hold_viol;
    int            onehot_viol;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic          prev_last;
    logic [SW-1:0] prev_tid;

    function automatic logic [DW-1:0] enc(input int j, input int p, input int b);
        return DW'(j * 4096 + p * 256 + b);
    endfunction

    function automatic logic [KW-1:0] kenc(input int j, input int b);
        return KW'(j * 64 + b);
    endfunction

    task automatic drive_src();
        for (int j = 0; j < N_SRC; j++) begin
            logic stall;
            stall = (src_pkts[j] > 0) && (src_beat[j] == src_stall_beat[j]) && (src_stall_left[j] > 0);
            if (stall) src_stall_left[j]--;
            tb_tvld[j]  = (src_pkts[j] > 0) && !stall;
            tb_tdata[j] = enc(j, src_pkt[j], src_beat[j]);
            tb_tkeep[j] = kenc(j, src_beat[j]);
            tb_tlast[j] = (src_beat[j] == src_len[j] - 1);
        end
    endtask

    task automatic tb_clear();
        for (int j = 0; j < N_SRC; j++) begin
            src_pkts[j] = 0; src_len[j] = 1; src_beat[j] = 0; src_pkt[j] = 0;
            src_stall_beat[j] = -1; src_stall_left[j] = 0; trdy_seen[j] = 1'b0;
        end
        q_tid.delete(); q_data.delete(); q_keep.delete(); q_last.delete();
        hold_viol = 0; onehot_viol = 0; prev_stall = 1'b0; m_rand = 1'b0;
        drive_src();
    endtask

    task automatic load(input int j, input int pkts, input int len);
        src_pkts[j] = pkts; src_len[j] = len; src_beat[j] = 0; src_pkt[j] = 0;
        drive_src();
    endtask

    // One clock: observe at negedge, advance sources and drive at posedge+1
    task automatic step();
        logic hs [N_SRC];
        int   ones;
        @(negedge clk);
        ones = 0;
        for (int j = 0; j < N_SRC; j++) begin
            hs[j] = tb_tvld[j] && tb_trdy[j];
            if (tb_trdy[j]) begin
                ones++;
                trdy_seen[j] = 1'b1;
            end
        end
        if (ones > 1) onehot_viol++;
        if (prev_stall && (m_tvld !== 1'b1 || m_tdata !== prev_data || m_tkeep !== prev_keep ||
                           m_tlast !== prev_last || m_tid !== prev_tid)) hold_viol++;
        prev_stall = m_tvld && !m_trdy;
        prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast; prev_tid = m_tid;
        if (m_tvld && m_trdy) begin
            q_tid.push_back(m_tid); q_data.push_back(m_tdata);
            q_keep.push_back(m_tkeep); q_last.push_back(m_tlast);
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < N_SRC; j++) begin
            if (hs[j]) begin
                src_beat[j]++;
                if (src_beat[j] == src_len[j]) begin
                    src_beat[j] = 0; src_pkt[j]++; src_pkts[j]--;
                end
            end
        end
        drive_src();
        if (m_rand) m_trdy = ($urandom_range(1, 0) == 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src_en = '1; m_trdy = 1'b0;
        tb_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();
        n_tests++;
        if (m_tvld !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle tvld=%0b busy=%0b required 0 0", m_tvld, busy);
        end
        load(0, 1, 4);
        step();
        n_tests++;
        if (busy !== 1'b1 || m_tvld !== 1'b0) begin
            n_fail++; $display("FAIL arb_cycle busy=%0b tvld=%0b required 1 0", busy, m_tvld);
        end
        step();
        n_tests++;
        if (m_tvld !== 1'b1 || m_tid !== SW'(0) || m_tdata !== enc(0, 0, 0) || m_tlast !== 1'b0) begin
            n_fail++; $display("FAIL first_beat tvld=%0b tid=%0d data=%0h required 1 0 %0h",
                               m_tvld, m_tid, m_tdata, enc(0, 0, 0));
        end
        n_tests++;
        if (s_trdy !== 4'b0000) begin
            n_fail++; $display("FAIL full_trdy trdy=%b required 0000", s_trdy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_tvld, m_tlast, m_tdata, m_tkeep, m_tid, s_trdy, busy} !== '0) begin
            n_fail++; $display("FAIL async_reset tvld=%0b last=%0b data=%0h keep=%0h tid=%0d trdy=%b busy=%0b required all 0",
                               m_tvld, m_tlast, m_tdata, m_tkeep, m_tid, s_trdy, busy);
        end
`ifdef STR_PKT_ARB_CNT_EN
        n_tests++;
        if (pkt_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt got=%0h required 0", pkt_cnt);
        end
`endif
        tb_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(); step();
        n_tests++;
        if (m_tvld !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset tvld=%0b busy=%0b required 0 0", m_tvld, busy);
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int pk    [5] = '{0, 0, 0, 0, 1};
        tb_clear(); src_en = '1; m_trdy = 1'b1;
        load(0, 2, 3); load(1, 1, 3); load(2, 1, 3); load(3, 1, 3);
        for (int c = 0; c < 200 && q_tid.size() < 15; c++) step();
        n_tests++;
        if (q_tid.size() != 15) begin
            n_fail++; $display("FAIL rr_count got=%0d required 15", q_tid.size());
        end
        for (int k = 0; k < 15 && k < q_tid.size(); k++) begin
            int p;
            int b;
            p = k / 3; b = k % 3;
            n_tests++;
            if (q_tid[k] !== SW'(order[p]) || q_data[k] !== enc(order[p], pk[p], b) ||
                q_keep[k] !== kenc(order[p], b) || q_last[k] !== (b == 2)) begin
                n_fail++; $display("FAIL rr_beat%0d tid=%0d data=%0h last=%0b required %0d %0h %0b",
                                   k, q_tid[k], q_data[k], q_last[k], order[p], enc(order[p], pk[p], b), (b == 2));
            end
        end
    endtask

    task automatic test_lock();
        int etid [8] = '{1, 1, 1, 1, 2, 2, 0, 0};
        int ebt  [8] = '{0, 1, 2, 3, 0, 1, 0, 1};
        tb_clear(); src_en = '1; m_trdy = 1'b1;
        load(1, 1, 4); src_stall_beat[1] = 2; src_stall_left[1] = 5;
        load(0, 1, 2); load(2, 1, 2);
        for (int c = 0; c < 200 && q_tid.size() < 8; c++) step();
        n_tests++;
        if (q_tid.size() != 8) begin
            n_fail++; $display("FAIL lock_count got=%0d required 8", q_tid.size());
        end
        for (int k = 0; k < 8 && k < q_tid.size(); k++) begin
            n_tests++;
            if (q_tid[k] !== SW'(etid[k]) || q_data[k] !== enc(etid[k], 0, ebt[k]) || q_last[k] !== (ebt[k] == (etid[k] == 1 ? 3 : 1))) begin
                n_fail++; $display("FAIL lock_beat%0d tid=%0d data=%0h required %0d %0h",
                                   k, q_tid[k], q_data[k], etid[k], enc(etid[k], 0, ebt[k]));
            end
        end
        n_tests++;
        if (onehot_viol != 0) begin
            n_fail++; $display("FAIL trdy_onehot violations=%0d required 0", onehot_viol);
        end
    endtask

    task automatic test_backpressure();
        tb_clear(); src_en = '1; m_trdy = 1'b1;
        load(0, 1, 16);
        m_rand = 1'b1;
        for (int c = 0; c < 400 && q_tid.size() < 16; c++) step();
        m_rand = 1'b0; m_trdy = 1'b1;
        n_tests++;
        if (q_tid.size() != 16) begin
            n_fail++; $display("FAIL bp_count got=%0d required 16", q_tid.size());
        end
        for (int k = 0; k < 16 && k < q_tid.size(); k++) begin
            n_tests++;
            if (q_data[k] !== DW'(k) || q_tid[k] !== SW'(0) || q_last[k] !== (k == 15)) begin
                n_fail++; $display("FAIL bp_beat%0d data=%0h last=%0b required %0h %0b",
                                   k, q_data[k], q_last[k], k, (k == 15));
            end
        end
        n_tests++;
        if (hold_viol != 0) begin
            n_fail++; $display("FAIL bp_hold violations=%0d required 0", hold_viol);
        end
    endtask

    task automatic test_mask();
        int etid [8] = '{1, 1, 3, 3, 1, 1, 3, 3};
        int ftid [6] = '{1, 1, 1, 1, 0, 0};
        int fbt  [6] = '{0, 1, 2, 3, 0, 1};
        tb_clear(); src_en = 4'b1010; m_trdy = 1'b1;
        for (int j = 0; j < N_SRC; j++) load(j, 2, 2);
        for (int c = 0; c < 200 && q_tid.size() < 8; c++) step();
        repeat (10) step();
        n_tests++;
        if (q_tid.size() != 8) begin
            n_fail++; $display("FAIL mask_count got=%0d required 8", q_tid.size());
        end
        for (int k = 0; k < 8 && k < q_tid.size(); k++) begin
            n_tests++;
            if (q_tid[k] !== SW'(etid[k]) || q_data[k] !== enc(etid[k], k / 4, k % 2)) begin
                n_fail++; $display("FAIL mask_beat%0d tid=%0d data=%0h required %0d %0h",
                                   k, q_tid[k], q_data[k], etid[k], enc(etid[k], k / 4, k % 2));
            end
        end
        n_tests++;
        if (trdy_seen[0] !== 1'b0 || trdy_seen[2] !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mask_blocked trdy0=%0b trdy2=%0b busy=%0b required 0 0 0",
                               trdy_seen[0], trdy_seen[2], busy);
        end
        tb_clear(); src_en = 4'b0010;
        load(1, 1, 4); load(0, 1, 2);
        step();
        src_en = 4'b0001;
        for (int c = 0; c < 200 && q_tid.size() < 6; c++) step();
        n_tests++;
        if (q_tid.size() != 6) begin
            n_fail++; $display("FAIL entog_count got=%0d required 6", q_tid.size());
        end
        for (int k = 0; k < 6 && k < q_tid.size(); k++) begin
            n_tests++;
            if (q_tid[k] !== SW'(ftid[k]) || q_data[k] !== enc(ftid[k], 0, fbt[k])) begin
                n_fail++; $display("FAIL entog_beat%0d tid=%0d data=%0h required %0d %0h",
                                   k, q_tid[k], q_data[k], ftid[k], enc(ftid[k], 0, fbt[k]));
            end
        end
    endtask

    task automatic test_single_beat();
        int cyc;
        rst_n = 1'b0;
        tb_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        src_en = '1; m_trdy = 1'b1;
        load(2, 5, 1);
        cyc = 0;
        while (cyc < 100 && q_tid.size() < 5) begin
            step();
            cyc++;
        end
        n_tests++;
        if (q_tid.size() != 5 || cyc != 11) begin
            n_fail++; $display("FAIL single_timing beats=%0d cycles=%0d required 5 11", q_tid.size(), cyc);
        end
        for (int k = 0; k < 5 && k < q_tid.size(); k++) begin
            n_tests++;
            if (q_tid[k] !== SW'(2) || q_data[k] !== enc(2, k, 0) || q_last[k] !== 1'b1) begin
                n_fail++; $display("FAIL single_beat%0d tid=%0d data=%0h last=%0b required 2 %0h 1",
                                   k, q_tid[k], q_data[k], q_last[k], enc(2, k, 0));
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle busy=%0b required 0", busy);
        end
`ifdef STR_PKT_ARB_CNT_EN
        n_tests++;
        if (pkt_cnt !== 8'h10) begin
            n_fail++; $display("FAIL pkt_cnt got=%0h required 10", pkt_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_mask();
        test_single_beat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
